uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single `uart_tx` serializer between `N_REQ` independent byte producers (debug printers, clock-count reporter, RAM dumper). It sits between the requesters and `uart_tx`, driving that serializer's `start`/`input_data` and watching its `complete`. A grant is held for a whole message (until a byte flagged `last`) so messages never interleave on the line. A burst limit stops one requester from monopolising the port.

---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 125 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte producers, the round-robin arbiter and the shared uart_tx.
// The slave modport is the arbiter's view; master is the surrounding environment's view.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   ack;
    logic [N_REQ-1:0]   grant;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               tx_complete;
    logic               busy;
    logic [15:0]        bytes_sent;

    modport slave (
        input  req, req_data, req_last, tx_complete,
        output ack, grant, tx_start, tx_data, busy, bytes_sent
    );

    modport master (
        output req, req_data, req_last, tx_complete,
        input  ack, grant, tx_start, tx_data, busy, bytes_sent
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between N_REQ byte producers.
// A grant is held for a whole message (up to a 'last' byte) or until MAX_BURST bytes have gone out.
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 64
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int              OW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [1:0]      ST_IDLE   = 2'd0;
    localparam logic [1:0]      ST_LOAD   = 2'd1;
    localparam logic [1:0]      ST_START  = 2'd2;
    localparam logic [1:0]      ST_WAIT   = 2'd3;
    localparam logic [7:0]      BURST_LIM = 8'(MAX_BURST);
    localparam logic [OW-1:0]   OWNER_RST = OW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [1:0]       state_r;
    logic [N_REQ-1:0] grant_r;
    logic [N_REQ-1:0] ack_r;
    logic [OW-1:0]    owner_r;
    logic [OW-1:0]    last_owner_r;
    logic [7:0]       tx_data_r;
    logic             last_r;
    logic [7:0]       burst_r;
    logic [15:0]      bytes_sent_r;
    logic             busy_r;
    logic [OW-1:0]    pick_s;
    logic [OW:0]      cand_s;

    // Round-robin pick: nearest requester after last_owner, wrapping; descending loop leaves the nearest.
    always_comb begin
        pick_s = last_owner_r;
        cand_s = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand_s = {1'b0, last_owner_r} + (OW+1)'(i);
            if (cand_s >= (OW+1)'(N_REQ)) begin
                cand_s = cand_s - (OW+1)'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (bus.req[cand_s[OW-1:0]]) begin
                pick_s = cand_s[OW-1:0];
            end else begin
                pick_s = pick_s;
            end
        end
    end

    // Arbitration FSM, byte latch, burst and frame counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            ack_r        <= '0;
            owner_r      <= '0;
            last_owner_r <= OWNER_RST;
            tx_data_r    <= 8'd0;
            last_r       <= 1'b0;
            burst_r      <= 8'd0;
            bytes_sent_r <= 16'd0;
            busy_r       <= 1'b0;
        end else begin
            ack_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    // Gating on tx_complete also covers a frame left running across a reset.
                    if ((bus.req != '0) && bus.tx_complete) begin
                        grant_r <= ONE_HOT0 << pick_s;
                        owner_r <= pick_s;
                        busy_r  <= 1'b1;
                        burst_r <= 8'd0;
                        state_r <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (bus.req[owner_r]) begin
                        tx_data_r      <= bus.req_data[{owner_r, 3'b000} +: 8];
                        last_r         <= bus.req_last[owner_r];
                        ack_r[owner_r] <= 1'b1;
                        burst_r        <= (burst_r == BURST_LIM) ? burst_r : burst_r + 8'd1;
                        state_r        <= ST_START;
                    end else begin
                        grant_r      <= '0;
                        busy_r       <= 1'b0;
                        last_owner_r <= owner_r;
                        state_r      <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (!bus.tx_complete) begin
                        bytes_sent_r <= bytes_sent_r + 16'd1;
                        state_r      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.tx_complete) begin
                        if (last_r || (burst_r == BURST_LIM)) begin
                            grant_r      <= '0;
                            busy_r       <= 1'b0;
                            last_owner_r <= owner_r;
                            state_r      <= ST_IDLE;
                        end else begin
                            state_r <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack        = ack_r;
    assign bus.grant      = grant_r;
    assign bus.tx_start   = (state_r == ST_START);
    assign bus.tx_data    = tx_data_r;
    assign bus.busy       = busy_r;
    assign bus.bytes_sent = bytes_sent_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requester model, negedge-driven serializer model, hand-computed line logs.
module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int FRAME = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();
    uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_chk = 0;
    int          n_pass = 0;
    logic [8:0]  rq_q [N][$];
    logic [11:0] line_q [$];
    logic [3:0]  grant_log [$];
    int          ack_cnt [N];
    int          start_cnt, bad_start, unstable, frame_cnt;
    logic        frame_rst;
    logic [7:0]  cur_byte;
    logic [3:0]  prev_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push(input int r, input logic last, input logic [7:0] d);
        rq_q[r].push_back({last, d});
    endtask

    function automatic logic [31:0] line_at(input int j);
        if (j < line_q.size()) return 32'(line_q[j]);
        else return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] glog_at(input int j);
        if (j < grant_log.size()) return 32'(grant_log[j]);
        else return 32'hDEAD_BEEF;
    endfunction

    // Serializer, requester queues and monitors, all evaluated at negedge in a fixed order.
    initial begin
        logic [8:0] head;
        bus.req = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_complete = 1'b1;
        frame_cnt = 0; start_cnt = 0; bad_start = 0; unstable = 0;
        frame_rst = 1'b0; cur_byte = 8'd0; prev_grant = 4'd0;
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (bus.tx_complete) begin
                if (bus.tx_start) begin
                    bus.tx_complete = 1'b0;
                    frame_cnt = FRAME;
                    cur_byte  = bus.tx_data;
                    frame_rst = 1'b0;
                    line_q.push_back({bus.grant, bus.tx_data});
                    start_cnt++;
                end
            end else begin
                if (bus.tx_start) bad_start++;
                frame_rst = frame_rst | rst;
                if (!frame_rst && (bus.tx_data !== cur_byte)) unstable++;
                frame_cnt--;
                if (frame_cnt == 0) bus.tx_complete = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (bus.ack[i]) begin
                    ack_cnt[i]++;
                    if (rq_q[i].size() != 0) void'(rq_q[i].pop_front());
                end
            end
            if (bus.grant != prev_grant) grant_log.push_back(bus.grant);
            prev_grant = bus.grant;
            for (int i = 0; i < N; i++) begin
                if (rq_q[i].size() != 0) begin
                    head = rq_q[i][0];
                    bus.req[i] = 1'b1;
                    bus.req_data[8*i +: 8] = head[7:0];
                    bus.req_last[i] = head[8];
                end else begin
                    bus.req[i] = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        line_q.delete(); grant_log.delete();
        start_cnt = 0;
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk); #1;
            done = (bus.grant == 4'd0) && bus.tx_complete;
            for (int i = 0; i < N; i++) if (rq_q[i].size() != 0) done = 1'b0;
        end
        chk({tag, "_settle"}, 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        string       msg;
        logic [11:0] exp2 [10];
        msg = "Pozdrowienia";
        exp2 = '{12'h101, 12'h102, 12'h211, 12'h212, 12'h421, 12'h422,
                 12'h831, 12'h832, 12'h105, 12'h106};

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_bytes_sent", 32'(bus.bytes_sent), 32'd0);
        rst = 1'b0;

        // Single requester 0 sends "Pozdrowienia"; grant and first-byte latency
        do_reset();
        for (int j = 0; j < 12; j++) push(0, (j == 11), 8'(msg[j]));
        @(negedge clk); #1;
        chk("t1_pre_grant", 32'(bus.grant), 32'd0);
        @(negedge clk); #1;
        chk("t1_grant", 32'(bus.grant), 32'd1);
        chk("t1_no_start_yet", 32'(bus.tx_start), 32'd0);
        chk("t1_no_ack_yet", 32'(bus.ack), 32'd0);
        @(negedge clk); #1;
        chk("t1_ack", 32'(bus.ack), 32'd1);
        chk("t1_tx_start", 32'(bus.tx_start), 32'd1);
        chk("t1_tx_data", 32'(bus.tx_data), 32'h50);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        wait_idle("t1", 1000);
        for (int j = 0; j < 12; j++) chk("t1_line", line_at(j), 32'({4'b0001, 8'(msg[j])}));
        chk("t1_line_len", 32'(line_q.size()), 32'd12);
        chk("t1_acks", 32'(ack_cnt[0]), 32'd12);
        chk("t1_starts", 32'(start_cnt), 32'd12);
        chk("t1_bytes_sent", 32'(bus.bytes_sent), 32'd12);
        chk("t1_busy_end", 32'(bus.busy), 32'd0);

        // All four request at once, 2-byte messages; requester 0 has a second message
        do_reset();
        push(0, 1'b0, 8'h01); push(0, 1'b1, 8'h02); push(0, 1'b0, 8'h05); push(0, 1'b1, 8'h06);
        push(1, 1'b0, 8'h11); push(1, 1'b1, 8'h12);
        push(2, 1'b0, 8'h21); push(2, 1'b1, 8'h22);
        push(3, 1'b0, 8'h31); push(3, 1'b1, 8'h32);
        wait_idle("t2", 1000);
        for (int j = 0; j < 10; j++) chk("t2_line", line_at(j), 32'(exp2[j]));
        chk("t2_line_len", 32'(line_q.size()), 32'd10);
        for (int j = 0; j < 10; j++)
            chk("t2_grant_seq", glog_at(j), (j % 2 == 1) ? 32'd0 : 32'(exp2[j][11:8]));
        chk("t2_bytes_sent", 32'(bus.bytes_sent), 32'd10);

        // Burst limit: requester 1 streams 70 bytes without last, requester 2 waiting
        do_reset();
        for (int j = 0; j < 70; j++) push(1, 1'b0, 8'(j));
        push(2, 1'b0, 8'hA0); push(2, 1'b0, 8'hA1); push(2, 1'b1, 8'hA2);
        wait_idle("t3", 3000);
        for (int j = 0; j < 64; j++) chk("t3_burst1", line_at(j), 32'({4'b0010, 8'(j)}));
        for (int j = 0; j < 3; j++) chk("t3_req2", line_at(64 + j), 32'({4'b0100, 8'(8'hA0 + j)}));
        for (int j = 0; j < 6; j++) chk("t3_resume1", line_at(67 + j), 32'({4'b0010, 8'(64 + j)}));
        chk("t3_line_len", 32'(line_q.size()), 32'd73);
        chk("t3_acks1", 32'(ack_cnt[1]), 32'd70);
        chk("t3_bytes_sent", 32'(bus.bytes_sent), 32'd73);

        // Owner abandons mid-message, next requester served
        do_reset();
        push(2, 1'b0, 8'h31); push(2, 1'b0, 8'h32);
        push(3, 1'b1, 8'h41);
        wait_idle("t4", 1000);
        chk("t4_line0", line_at(0), 32'h431);
        chk("t4_line1", line_at(1), 32'h432);
        chk("t4_line2", line_at(2), 32'h841);
        chk("t4_starts", 32'(start_cnt), 32'd3);
        chk("t4_glog0", glog_at(0), 32'h4);
        chk("t4_glog1", glog_at(1), 32'h0);
        chk("t4_glog2", glog_at(2), 32'h8);
        chk("t4_glog3", glog_at(3), 32'h0);
        chk("t4_glog_len", 32'(grant_log.size()), 32'd4);
        chk("t4_bytes_sent", 32'(bus.bytes_sent), 32'd3);

        // Reset three cycles after tx_start with a frame in flight
        do_reset();
        push(0, 1'b0, 8'h51); push(0, 1'b0, 8'h52); push(0, 1'b1, 8'h53);
        for (int n = 0; n < 50 && !bus.tx_start; n++) begin
            @(negedge clk); #1;
        end
        chk("t5_start_seen", 32'(bus.tx_start), 32'd1);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_grant", 32'(bus.grant), 32'd0);
        chk("t5_tx_start", 32'(bus.tx_start), 32'd0);
        chk("t5_ack", 32'(bus.ack), 32'd0);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_tx_data", 32'(bus.tx_data), 32'd0);
        chk("t5_bytes_sent", 32'(bus.bytes_sent), 32'd0);
        chk("t5_line_busy", 32'(bus.tx_complete), 32'd0);
        @(negedge clk); #1 rst = 1'b0;
        wait_idle("t5", 1000);
        chk("t5_line0", line_at(0), 32'h151);
        chk("t5_line1", line_at(1), 32'h152);
        chk("t5_line2", line_at(2), 32'h153);
        chk("t5_bytes_after", 32'(bus.bytes_sent), 32'd2);

        // bytes_sent wraps from 0xFFFF to 0
        do_reset();
        @(negedge clk);
        force dut.bytes_sent_r = 16'hFFFF;
        @(negedge clk); #1;
        release dut.bytes_sent_r;
        #1;
        chk("t6_preload", 32'(bus.bytes_sent), 32'hFFFF);
        push(1, 1'b1, 8'h7E);
        wait_idle("t6", 500);
        chk("t6_wrap", 32'(bus.bytes_sent), 32'd0);
        chk("t6_line", line_at(0), 32'h27E);

        chk("no_start_while_busy", 32'(bad_start), 32'd0);
        chk("tx_data_stable", 32'(unstable), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
